// File: rtl/counter.sv
// Prescaled modulo-(MAX_COUNT+1) counter with wrap pulse and hex seven-segment decode.
// Optional macro COUNTER_SEG_REG_EN registers the segment output (one cycle behind count).
module counter #(
    parameter int MAX_COUNT = 15,
    parameter int DIV       = 1
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] count,
    output logic       wrap,
    output logic [6:0] seg
);

    localparam logic [3:0]  MAX_Q  = 4'(MAX_COUNT);
    localparam logic [15:0] DIV_M1 = 16'(DIV - 1);
    localparam logic [6:0]  SEG_0  = 7'b0111111;

    logic [15:0] presc;
    logic        tick;
    logic [6:0]  seg_next;

    assign tick = (presc == DIV_M1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 16'd1;
        end
    end

    // Any value at or above MAX_COUNT (including illegal ones) returns to 0 on the tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= tick && (count == MAX_Q);
            if (tick) begin
                count <= (count < MAX_Q) ? count + 4'd1 : 4'd0;
            end
        end
    end

    // Segment order is {g,f,e,d,c,b,a}, active high.
    always_comb begin
        seg_next = SEG_0;
        case (count)
            4'h0: seg_next = 7'b0111111;
            4'h1: seg_next = 7'b0000110;
            4'h2: seg_next = 7'b1011011;
            4'h3: seg_next = 7'b1001111;
            4'h4: seg_next = 7'b1100110;
            4'h5: seg_next = 7'b1101101;
            4'h6: seg_next = 7'b1111101;
            4'h7: seg_next = 7'b0000111;
            4'h8: seg_next = 7'b1111111;
            4'h9: seg_next = 7'b1101111;
            4'hA: seg_next = 7'b1110111;
            4'hB: seg_next = 7'b1111100;
            4'hC: seg_next = 7'b0111001;
            4'hD: seg_next = 7'b1011110;
            4'hE: seg_next = 7'b1111001;
            4'hF: seg_next = 7'b1110001;
            default: seg_next = SEG_0;
        endcase
    end

`ifdef COUNTER_SEG_REG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg <= SEG_0;
        end else begin
            seg <= seg_next;
        end
    end
`else
    assign seg = seg_next;
`endif

endmodule

// File: tb/tb_counter.sv
// Directed bench for counter: defaults, MAX_COUNT=9 and DIV=4 instances on a shared clock/reset.
module tb_counter;

    logic       clk;
    logic       rst;
    logic [3:0] cnt_def, cnt_m9, cnt_d4;
    logic       wrap_def, wrap_m9, wrap_d4;
    logic [6:0] seg_def, seg_m9, seg_d4;

    int n_pass = 0;
    int n_total = 0;

    counter u_def (.clk(clk), .rst(rst), .count(cnt_def), .wrap(wrap_def), .seg(seg_def));
    counter #(.MAX_COUNT(9)) u_m9 (.clk(clk), .rst(rst), .count(cnt_m9), .wrap(wrap_m9), .seg(seg_m9));
    counter #(.DIV(4)) u_d4 (.clk(clk), .rst(rst), .count(cnt_d4), .wrap(wrap_d4), .seg(seg_d4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'b0111111;  4'h1: g = 7'b0000110;
            4'h2: g = 7'b1011011;  4'h3: g = 7'b1001111;
            4'h4: g = 7'b1100110;  4'h5: g = 7'b1101101;
            4'h6: g = 7'b1111101;  4'h7: g = 7'b0000111;
            4'h8: g = 7'b1111111;  4'h9: g = 7'b1101111;
            4'hA: g = 7'b1110111;  4'hB: g = 7'b1111100;
            4'hC: g = 7'b0111001;  4'hD: g = 7'b1011110;
            4'hE: g = 7'b1111001;  default: g = 7'b1110001;
        endcase
        return g;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
    endtask

    // Expected seg for the current count, given the previous expected count.
    function automatic logic [6:0] exp_seg(input logic [3:0] cur, input logic [3:0] prev);
`ifdef COUNTER_SEG_REG_EN
        return glyph(prev);
`else
        return glyph(cur);
`endif
    endfunction

    logic [3:0] e_def, e_m9, e_d4, p_def, p_m9, p_d4;

    initial begin
        rst = 1'b0;
        #1;
        check("rst_count", {4'd0, cnt_def}, 8'd0);
        check("rst_wrap", {7'd0, wrap_def}, 8'd0);
        check("rst_seg", {1'b0, seg_def}, 8'h3F);
        @(posedge clk); #1;
        check("rst_edge_count", {4'd0, cnt_def}, 8'd0);
        check("rst_edge_seg", {1'b0, seg_def}, 8'h3F);
        check("rst_edge_d4", {4'd0, cnt_d4}, 8'd0);
        #4 rst = 1'b1;

        p_def = 4'd0; p_m9 = 4'd0; p_d4 = 4'd0;
        for (int k = 1; k <= 55; k++) begin
            @(posedge clk); #1;
            e_def = 4'(k % 16);
            e_m9  = 4'(k % 10);
            e_d4  = 4'(k / 4);
            check("def_count", {4'd0, cnt_def}, {4'd0, e_def});
            check("def_wrap", {7'd0, wrap_def}, {7'd0, (k % 16) == 0});
            check("def_seg", {1'b0, seg_def}, {1'b0, exp_seg(e_def, p_def)});
            check("m9_count", {4'd0, cnt_m9}, {4'd0, e_m9});
            check("m9_wrap", {7'd0, wrap_m9}, {7'd0, (k % 10) == 0});
            check("m9_seg", {1'b0, seg_m9}, {1'b0, exp_seg(e_m9, p_m9)});
            check("d4_count", {4'd0, cnt_d4}, {4'd0, e_d4});
            check("d4_wrap", {7'd0, wrap_d4}, 8'd0);
            check("d4_seg", {1'b0, seg_d4}, {1'b0, exp_seg(e_d4, p_d4)});
            p_def = e_def; p_m9 = e_m9; p_d4 = e_d4;
        end

        // Mid-count async reset at default count 7, between edges.
        #2 rst = 1'b0;
        #1;
        check("mid_rst_count", {4'd0, cnt_def}, 8'd0);
        check("mid_rst_wrap", {7'd0, wrap_def}, 8'd0);
        check("mid_rst_seg", {1'b0, seg_def}, 8'h3F);
        check("mid_rst_m9", {4'd0, cnt_m9}, 8'd0);
        check("mid_rst_d4", {4'd0, cnt_d4}, 8'd0);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_count", {4'd0, cnt_def}, 8'd1);
        check("post_rst_wrap", {7'd0, wrap_def}, 8'd0);
        check("post_rst_seg", {1'b0, seg_def}, {1'b0, exp_seg(4'd1, 4'd0)});
        check("post_rst_m9", {4'd0, cnt_m9}, 8'd1);
        check("post_rst_d4", {4'd0, cnt_d4}, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
